// File: rtl/oflow_mem_buffer_pkg.sv
// Shared types and default widths for the previous-frame memory-buffer read path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package oflow_mem_buffer_pkg;

  // Default widths: one 128-bit bbox record per line, up to 256 lines.
  localparam int BUF_DATA_WIDTH   = 128;
  localparam int BUF_ADDR_LEN     = 8;
  localparam int BUF_LINE_CNT_LEN = 9;

  // Largest pass length; one more than the highest 8-bit address.
  localparam int MAX_LINES = 256;

  typedef enum logic [2:0] {
    idle_st,
    rd_st,
    wait_st,
    hold_st,
    done_st
  } buf_rd_state_t;

endpackage

// File: rtl/oflow_mem_buffer_fsm_read.sv
// Walks the previous-frame bbox memory one line per pass step and broadcasts
// each line to the similarity PEs. Latency: start_read -> first line valid in
// 3 cycles, read_new_line -> next line valid in 3 cycles. Backpressure: each
// line is held until read_new_line; start_read outside idle is dropped.
//
// Ports:
//   clk, reset_N     : clock, synchronous active-high reset
//   start_read       : one-cycle pass start from the core read FSM
//   read_new_line    : core has consumed the presented line
//   num_of_lines     : pass length, sampled on an accepted start_read (clamped to 256)
//   mem_rd_en/addr   : synchronous RAM read port, data returns on mem_rdata next cycle
//   line_data/valid/index : registered line broadcast to the PEs
//   done_read        : one-cycle end-of-pass pulse
//   busy             : high whenever the sequencer is not idle
module oflow_mem_buffer_fsm_read
  import oflow_mem_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = BUF_DATA_WIDTH,
  parameter int ADDR_LEN     = BUF_ADDR_LEN,
  parameter int LINE_CNT_LEN = BUF_LINE_CNT_LEN
) (
  input  logic                    clk,
  input  logic                    reset_N,
  input  logic                    start_read,
  input  logic                    read_new_line,
  input  logic [LINE_CNT_LEN-1:0] num_of_lines,
  output logic                    mem_rd_en,
  output logic [ADDR_LEN-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [DATA_WIDTH-1:0]   line_data,
  output logic                    line_valid,
  output logic [ADDR_LEN-1:0]     line_index,
  output logic                    done_read,
  output logic                    busy
);

  localparam logic [LINE_CNT_LEN-1:0] MAX_LINES_C = LINE_CNT_LEN'(MAX_LINES);

  buf_rd_state_t           state;
  logic [ADDR_LEN-1:0]     line_cnt;
  logic [LINE_CNT_LEN-1:0] lines_reg;

  logic [LINE_CNT_LEN-1:0] lines_clamped;
  logic [LINE_CNT_LEN-1:0] last_idx;
  logic                    is_last;
  logic [ADDR_LEN-1:0]     next_cnt;

  // Counts above the memory depth are clamped so line_cnt never wraps.
  assign lines_clamped = (num_of_lines > MAX_LINES_C) ? MAX_LINES_C : num_of_lines;
  // lines_reg is never 0 while in hold_st, so last_idx cannot underflow there.
  assign last_idx      = lines_reg - LINE_CNT_LEN'(1);
  assign is_last       = (LINE_CNT_LEN'(line_cnt) == last_idx);
  assign next_cnt      = line_cnt + ADDR_LEN'(1);

  // All outputs are registered and set on the edge that enters their state,
  // so mem_rd_en/mem_addr/done_read/busy line up exactly with the state register.
  always_ff @(posedge clk) begin
    if (reset_N) begin
      state      <= idle_st;
      line_cnt   <= '0;
      lines_reg  <= '0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      line_data  <= '0;
      line_valid <= 1'b0;
      line_index <= '0;
      done_read  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Single-cycle outputs default low; only the entering transition raises them.
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      done_read <= 1'b0;

      case (state)
        idle_st: begin
          if (start_read) begin
            lines_reg <= lines_clamped;
            line_cnt  <= '0;
            busy      <= 1'b1;
            if (num_of_lines == '0) begin
              state     <= done_st;
              done_read <= 1'b1;
            end else begin
              state     <= rd_st;
              mem_rd_en <= 1'b1;
              mem_addr  <= '0;
            end
          end
        end

        rd_st: begin
          state <= wait_st;
        end

        // RAM data for the address issued in rd_st is valid now.
        wait_st: begin
          line_data  <= mem_rdata;
          line_index <= line_cnt;
          line_valid <= 1'b1;
          state      <= hold_st;
        end

        // start_read is not looked at here, so a coincident pulse is dropped.
        hold_st: begin
          if (read_new_line) begin
            line_valid <= 1'b0;
            if (is_last) begin
              state     <= done_st;
              done_read <= 1'b1;
            end else begin
              line_cnt  <= next_cnt;
              state     <= rd_st;
              mem_rd_en <= 1'b1;
              mem_addr  <= next_cnt;
            end
          end
        end

        done_st: begin
          state <= idle_st;
          busy  <= 1'b0;
        end

        default: begin
          state <= idle_st;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/oflow_mem_buffer_fsm_read.md
# oflow_mem_buffer_fsm_read

Memory-buffer read sequencer directly downstream of the core read FSM. On each `start_read` pulse it walks the previous-frame bbox memory one line at a time and presents each line to all similarity-metric PEs. It advances only when the core raises `read_new_line`, and it reports end-of-pass with a one-cycle `done_read` pulse.

## Interface
Parameters:
- `DATA_WIDTH`, 128: width of one memory line (one previous-frame bbox record).
- `ADDR_LEN`, 8: memory address width; up to 256 lines.
- `LINE_CNT_LEN`, 9: width of `num_of_lines`, so 256 is representable.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_N`, in, 1: synchronous, active-high reset (asserted = 1, sampled on `clk`).
- `start_read`, in, 1: one-cycle pulse from the core read FSM; starts a pass.
- `read_new_line`, in, 1: from the core read FSM; all active PEs consumed the current line.
- `num_of_lines`, in, `LINE_CNT_LEN`: previous-frame bbox count; sampled on an accepted `start_read`.
- `mem_rd_en`, out, 1: memory read enable.
- `mem_addr`, out, `ADDR_LEN`: memory read address.
- `mem_rdata`, in, `DATA_WIDTH`: synchronous-RAM read data, valid the cycle after `mem_rd_en`.
- `line_data`, out, `DATA_WIDTH`: registered line broadcast to the PEs.
- `line_valid`, out, 1: `line_data` is valid and held.
- `line_index`, out, `ADDR_LEN`: index of the presented line.
- `done_read`, out, 1: one-cycle pulse at the end of a pass.
- `busy`, out, 1: high in every state except `idle_st`.

## Operation
- States: `idle_st`, `rd_st`, `wait_st`, `hold_st`, `done_st`.
- `idle_st`:
  - On `start_read`, latch `num_of_lines` into `lines_reg` and clear `line_cnt`.
  - If `num_of_lines` is 0, go to `done_st`; otherwise go to `rd_st`.
- `rd_st`:
  - Drive `mem_rd_en`=1 and `mem_addr`=`line_cnt`.
  - Go to `wait_st` unconditionally.
- `wait_st`:
  - Register `mem_rdata` into `line_data` and `line_cnt` into `line_index`.
  - Set `line_valid`; go to `hold_st`.
- `hold_st`: hold `line_data` and `line_valid` until `read_new_line`. When it arrives:
  - Clear `line_valid`.
  - If `line_cnt == lines_reg-1`, go to `done_st`.
  - Otherwise increment `line_cnt` and go to `rd_st`.
- `done_st`: `done_read`=1 for this cycle only; go to `idle_st`.
- `start_read` outside `idle_st` is ignored; no restart and no queuing.
- `read_new_line` outside `hold_st` is ignored.
- `lines_reg` is frozen for the whole pass; changes on `num_of_lines` mid-pass have no effect.
- `line_cnt` never wraps: the maximum is `lines_reg-1`, at most 255. A `num_of_lines` above 256 is clamped to 256.
- `mem_rd_en` is a Moore output, high only in `rd_st`. `mem_addr` is 0 outside `rd_st`.

## Timing
- Reset value of every output is 0, state is `idle_st`, and `line_cnt` and `lines_reg` are 0.
- Reset asserted mid-pass aborts the pass: state returns to `idle_st` on the next edge, no `done_read` is issued, and `line_data` is cleared.
- `start_read` high in cycle k gives:
  - `rd_st` in k+1, with `mem_rd_en`=1;
  - `wait_st` in k+2;
  - `line_valid`=1 from k+3.
- `read_new_line` in cycle m of `hold_st`:
  - if more lines remain: `line_valid`=0 in m+1 (`rd_st`), and the next line is valid from m+3. Per-line turnaround is 3 cycles.
  - on the last line: `done_read`=1 in cycle m+1, `idle_st` in m+2, and a new `start_read` is accepted in m+2.
- Zero lines: `start_read` in cycle k gives `done_read` in k+1.
- `start_read` and `read_new_line` in the same cycle while in `hold_st`: `read_new_line` is processed and `start_read` is dropped.

## Structure
- Shared package `oflow_mem_buffer_pkg` holds:
  - `DATA_WIDTH`, `ADDR_LEN`, `LINE_CNT_LEN` defaults;
  - the `buf_rd_state_t` enum;
  - the `MAX_LINES`=256 constant.
  These join the existing `oflow_MEM_buffer_define` widths.
- The block is a single module: one FSM, the `line_cnt`/`lines_reg` counters, and the output line register.
- No sub-module is needed. The line register is inline, not a separate instance.

## Test plan
- Reset, then `start_read` with `num_of_lines`=3 and memory loaded as line i = 0xA0+i:
  - `mem_addr` sequence 0,1,2;
  - `line_data` sequence 0xA0, 0xA1, 0xA2, each first valid 3 cycles after the preceding `start_read`/`read_new_line`;
  - a single `done_read` pulse 1 cycle after the third `read_new_line`.
- `num_of_lines`=0: `start_read` in cycle k gives `done_read` in k+1, and `mem_rd_en` never asserts.
- `read_new_line` held low for 20 cycles in `hold_st`: `line_data`, `line_valid` and `line_index` stay stable; no extra `mem_rd_en`.
- Spurious inputs:
  - `start_read` during `hold_st` of line 1 of 4 is ignored, and the pass finishes with `line_index` 0..3.
  - `read_new_line` in `idle_st`/`rd_st` causes no change.
- `reset_N` asserted in `wait_st` of line 2: all outputs are 0 next cycle and no `done_read`. A following `start_read` with 2 lines restarts at address 0.
- `num_of_lines`=256 with back-to-back `read_new_line`: addresses 0..255 with no wrap, and exactly one `done_read`.
